td4_prog_loader: RTL
====================

// Module: td4_prog_loader
// PURPOSE
//   Writer side of the TD4 program-ROM interface. Receives a 16-byte program plus one
//   checksum byte over a valid/ready byte stream and stores it in an internal 16x8 memory.
//   The CPU reads that memory through rom_adr/rom_data, so this block replaces td4_rom.
//   The loader holds the CPU in reset until a program has loaded and its checksum has passed.
// PARAMETERS
//   ADDR_W       4  program address width; memory depth is 2**ADDR_W words
//   DATA_W       8  instruction width
//   CHECKSUM_EN  1  1: require a trailing checksum byte; 0: go to RUN after the last program byte
// PORTS
//   clk         in   1       system clock; all state changes on the rising edge
//   reset       in   1       synchronous, active-high reset
//   load_start  in   1       one-cycle pulse; starts (or restarts) a program load
//   in_valid    in   1       in_data holds a byte
//   in_data     in   DATA_W  program/checksum byte
//   in_ready    out  1       loader accepts a byte this cycle
//   rom_adr     in   ADDR_W  CPU fetch address
//   rom_data    out  DATA_W  mem[rom_adr]; combinational read
//   cpu_reset   out  1       drives the CPU reset input; registered
//   busy        out  1       1 in LOAD or CHECK
//   load_ok     out  1       last load passed; sticky until the next load_start or reset
//   load_err    out  1       last load failed its checksum; sticky until the next load_start or reset
// BEHAVIOUR
//   Reset
//   - Next state is HALT. All memory words, wr_ptr and sum clear to 0.
//   - Outputs after reset: cpu_reset=1, in_ready=0, busy=0, load_ok=0, load_err=0.
//   - Reset applied mid-load aborts the load. Memory is cleared, so no partial program survives.
//   States: HALT, LOAD, CHECK, RUN
//   - HALT: cpu_reset=1, in_ready=0. load_start moves to LOAD.
//   - LOAD: in_ready=1.
//     - A transfer occurs when in_valid && in_ready.
//     - Each transfer: mem[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1; sum <= sum+in_data (mod 2**DATA_W).
//     - The transfer at wr_ptr == 2**ADDR_W-1 wraps wr_ptr to 0.
//     - That last transfer moves to CHECK, or to RUN when CHECKSUM_EN=0.
//   - CHECK: in_ready=1. One transfer is accepted.
//     - If (sum+in_data) mod 256 == 0: move to RUN and set load_ok.
//     - Otherwise: move to HALT and set load_err.
//     - The checksum byte is never written to memory.
//   - RUN: cpu_reset=0, in_ready=0. load_start moves to LOAD.
//   - Entering LOAD from any state: wr_ptr=0, sum=0, load_ok=0, load_err=0.
//   - cpu_reset is 1 in every state except RUN.
//   Timing
//   - cpu_reset is registered from the next state.
//   - It falls on the same edge that enters RUN, i.e. the edge that accepts the final byte.
//   - It rises on the edge that enters LOAD.
//   - in_ready and busy decode combinationally from the state register.
//   - A byte accepted at edge N is visible on rom_data from edge N, with zero read latency.
//   Boundary and priority rules
//   - No transfer occurs without in_valid. Gaps in in_valid neither stall nor corrupt the pointer.
//   - load_start while in LOAD or CHECK restarts the load: wr_ptr=0, sum=0.
//     - Memory words already written are kept until they are overwritten.
//   - load_start in the same cycle as a transfer: the restart wins and that byte is discarded.
//   - reset has priority over everything.
//   - in_valid outside LOAD/CHECK is ignored.
//   - rom_adr may change at any time. Reads never alter state.
// TESTING
//   1. Reset, then load_start, then bytes 01 E0 51 F0 followed by 12x 00, then checksum DE
//      -> load_ok=1, cpu_reset=0 on the edge that accepts DE; rom_adr=1 gives rom_data=E0.
//   2. Same program with checksum 00
//      -> load_err=1, load_ok=0, state HALT, cpu_reset stays 1, in_ready=0.
//   3. in_valid toggled 1,0,0,1 per cycle throughout the load
//      -> exactly 17 transfers, memory matches scenario 1, no extra writes.
//   4. After 5 bytes, pulse load_start together with in_valid=1, data=AA
//      -> AA is discarded, wr_ptr=0, the next byte lands at address 0.
//   5. reset asserted after 9 bytes
//      -> all 16 words read 00, cpu_reset=1, busy=0, then a fresh full load succeeds.
//   6. CHECKSUM_EN=0 with 16 bytes
//      -> RUN entered on the 16th transfer, load_ok=1, in_ready=0 afterwards.

Source files
------------

// File: rtl/td4_prog_loader.sv
// TD4 program loader: accepts a 16-byte program plus optional checksum over valid/ready,
// stores it in a 16x8 memory read by the CPU, and holds the CPU in reset until the load succeeds.
module td4_prog_loader #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter bit CHECKSUM_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rom_adr,
    output logic [DATA_W-1:0] rom_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              load_ok,
    output logic              load_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [DATA_W-1:0]   sum_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic                cpu_reset_r;
    logic                load_ok_r;
    logic                load_err_r;
    logic                in_ready_s;
    logic                xfer_s;
    logic [DATA_W-1:0]   check_sum_s;

    // Modular byte sum used for both the running sum and the final checksum test.
    function automatic logic [DATA_W-1:0] sum_mod(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    assign in_ready_s  = (state_r == ST_LOAD) || (state_r == ST_CHECK);
    assign xfer_s      = in_valid && in_ready_s;
    assign check_sum_s = sum_mod(sum_r, in_data);

    assign in_ready  = in_ready_s;
    assign busy      = in_ready_s;
    assign rom_data  = mem_r[rom_adr];
    assign cpu_reset = cpu_reset_r;
    assign load_ok   = load_ok_r;
    assign load_err  = load_err_r;

    // Loader state machine, program memory writes and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_HALT;
            wr_ptr_r    <= {ADDR_W{1'b0}};
            sum_r       <= {DATA_W{1'b0}};
            cpu_reset_r <= 1'b1;
            load_ok_r   <= 1'b0;
            load_err_r  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (load_start) begin
            // A restart discards any byte offered in the same cycle.
            state_r     <= ST_LOAD;
            wr_ptr_r    <= {ADDR_W{1'b0}};
            sum_r       <= {DATA_W{1'b0}};
            cpu_reset_r <= 1'b1;
            load_ok_r   <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_HALT: begin
                    cpu_reset_r <= 1'b1;
                end
                ST_LOAD: begin
                    if (xfer_s) begin
                        mem_r[wr_ptr_r] <= in_data;
                        wr_ptr_r        <= wr_ptr_r + ADDR_W'(1);
                        sum_r           <= check_sum_s;
                        if (wr_ptr_r == LAST_ADDR) begin
                            if (CHECKSUM_EN) begin
                                state_r <= ST_CHECK;
                            end else begin
                                state_r     <= ST_RUN;
                                cpu_reset_r <= 1'b0;
                                load_ok_r   <= 1'b1;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    if (xfer_s) begin
                        if (check_sum_s == {DATA_W{1'b0}}) begin
                            state_r     <= ST_RUN;
                            cpu_reset_r <= 1'b0;
                            load_ok_r   <= 1'b1;
                        end else begin
                            state_r     <= ST_HALT;
                            cpu_reset_r <= 1'b1;
                            load_err_r  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    cpu_reset_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_HALT;
                    cpu_reset_r <= 1'b1;
                end
            endcase
        end
    end

endmodule
